// File: rtl/dmem_responder.sv
// Purpose : single-outstanding word memory responder with IDLE/BUSY/RESP handshake FSM.
// Latency : resp_valid rises LATENCY cycles after the accepting edge; one request per LATENCY+2 cycles.
// Backpres: req_ready only in IDLE; a response is held stable in RESP until resp_ready=1.
//
// Ports   : CLK, reset (sync, active-high); req_valid/req_ready/req_we/req_addr/req_wdata/req_be
//           request channel; resp_valid/resp_ready/resp_rdata/resp_err response channel.
// Macro   : DMEM_BYTE_EN -- when defined, writes honour req_be per byte; otherwise every
//           write updates the whole word and req_be is ignored.
// Params  : DEPTH words of 32-bit storage; LATENCY in 1..15.

module dmem_responder #(
    parameter int DEPTH   = 256,
    parameter int LATENCY = 2
) (
    input  logic        CLK,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_be,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t      state;
    logic [3:0]  cnt;

    // Request fields captured at acceptance; the live inputs are ignored afterwards.
    logic        we_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
`ifdef DMEM_BYTE_EN
    logic [3:0]  be_q;
`endif

    logic [31:0] mem [DEPTH];

    logic [29:0]   word_idx;
    logic [AW-1:0] mem_idx;
    logic          acc_err;
    logic          access_now;
    logic          commit;

    assign word_idx   = addr_q[31:2];
    assign mem_idx    = word_idx[AW-1:0];
    assign acc_err    = (addr_q[1:0] != 2'b00) || ({2'b00, word_idx} >= 32'(DEPTH));
    assign access_now = (state == BUSY) && (cnt == 4'd0);
    // Reset is folded in here so an aborted write never reaches storage.
    assign commit     = !reset && access_now && we_q && !acc_err;

    // Control FSM with registered handshake outputs.
    always_ff @(posedge CLK) begin
        if (reset) begin
            state      <= IDLE;
            cnt        <= 4'd0;
            req_ready  <= 1'b1;
            resp_valid <= 1'b0;
            resp_rdata <= 32'd0;
            resp_err   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid && req_ready) begin
                        we_q      <= req_we;
                        addr_q    <= req_addr;
                        wdata_q   <= req_wdata;
`ifdef DMEM_BYTE_EN
                        be_q      <= req_be;
`endif
                        cnt       <= 4'(LATENCY - 1);
                        req_ready <= 1'b0;
                        state     <= BUSY;
                    end
                end
                BUSY: begin
                    if (cnt == 4'd0) begin
                        state      <= RESP;
                        resp_valid <= 1'b1;
                        resp_err   <= acc_err;
                        // Reads return the whole word; writes and errors return zero.
                        resp_rdata <= (!we_q && !acc_err) ? mem[mem_idx] : 32'd0;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                RESP: begin
                    // req_ready comes up the cycle after the handshake, never the same one.
                    if (resp_ready) begin
                        state      <= IDLE;
                        resp_valid <= 1'b0;
                        resp_rdata <= 32'd0;
                        resp_err   <= 1'b0;
                        req_ready  <= 1'b1;
                    end
                end
                default: begin
                    state      <= IDLE;
                    req_ready  <= 1'b1;
                    resp_valid <= 1'b0;
                end
            endcase
        end
    end

    // Storage has no reset; it is written only on the BUSY->RESP edge.
    always_ff @(posedge CLK) begin
        if (commit) begin
`ifdef DMEM_BYTE_EN
            for (int i = 0; i < 4; i++) begin
                if (be_q[i]) begin
                    mem[mem_idx][8*i +: 8] <= wdata_q[8*i +: 8];
                end
            end
`else
            mem[mem_idx] <= wdata_q;
`endif
        end
    end

`ifndef DMEM_BYTE_EN
    logic unused_be;
    assign unused_be = ^req_be;
`endif

endmodule

// File: tb/tb_dmem_responder.sv
module tb_dmem_responder;

    localparam int DEPTH = 256;
    localparam int LAT   = 2;
    localparam int NWORD = 16;   // working set of words the bench keeps initialised

    logic        CLK = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [31:0] req_addr = 32'd0;
    logic [31:0] req_wdata = 32'd0;
    logic [3:0]  req_be = 4'd0;
    logic        resp_valid;
    logic        resp_ready = 1'b0;
    logic [31:0] resp_rdata;
    logic        resp_err;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] mem_m [DEPTH];

    dmem_responder #(.DEPTH(DEPTH), .LATENCY(LAT)) dut (
        .CLK        (CLK),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .req_be     (req_be),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] merge_word(input logic [31:0] old_w, input logic [31:0] new_w,
                                               input logic [3:0] be);
        logic [31:0] r;
        r = new_w;
`ifdef DMEM_BYTE_EN
        r = old_w;
        for (int i = 0; i < 4; i++) if (be[i]) r[8*i +: 8] = new_w[8*i +: 8];
`endif
        return r;
    endfunction

    function automatic logic addr_err(input logic [31:0] a);
        return (a[1:0] != 2'b00) || ((a >> 2) >= 32'(DEPTH));
    endfunction

    // Present junk on the request inputs while the block is not idle.
    task automatic drive_junk();
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_addr  = 32'($urandom_range(0, NWORD-1)) << 2;
        req_wdata = $urandom;
        req_be    = 4'hF;
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while (!req_ready && n < 50) begin @(posedge CLK); #1; n++; end
        chk(tag, 32'(req_ready), 32'd1);
    endtask

    // One full transaction: accept, check latency, hold the response for `hold` cycles,
    // then complete the handshake. The model is updated and the expected result checked.
    task automatic do_req(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [3:0] be, input int hold, output logic [31:0] rd);
        int n;
        logic        e_err;
        logic [31:0] e_rd;
        logic [31:0] s_rd;
        logic        s_err;
        wait_idle("idle_wait");
        e_err = addr_err(addr);
        e_rd  = 32'd0;
        if (!e_err) begin
            if (we) mem_m[addr >> 2] = merge_word(mem_m[addr >> 2], wdata, be);
            else    e_rd = mem_m[addr >> 2];
        end
        req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata; req_be = be;
        @(posedge CLK); #1;
        chk("rdy_after_acc", 32'(req_ready), 32'd0);
        n = 0;
        while (!resp_valid && n < LAT + 4) begin
            drive_junk();
            @(posedge CLK); #1; n++;
        end
        chk("latency", 32'(n), 32'(LAT));
        chk("rdata", resp_rdata, e_rd);
        chk("err", 32'(resp_err), 32'(e_err));
        s_rd = resp_rdata; s_err = resp_err;
        for (int i = 0; i < hold; i++) begin
            drive_junk();
            @(posedge CLK); #1;
            chk("hold_valid", 32'(resp_valid), 32'd1);
            chk("hold_rdata", resp_rdata, s_rd);
            chk("hold_err", 32'(resp_err), 32'(s_err));
            chk("hold_rdy", 32'(req_ready), 32'd0);
        end
        req_valid = 1'b0;
        resp_ready = 1'b1;
        @(posedge CLK); #1;
        resp_ready = 1'b0;
        chk("done_valid", 32'(resp_valid), 32'd0);
        chk("done_rdy", 32'(req_ready), 32'd1);
        rd = s_rd;
    endtask

    initial begin
        logic [31:0] rd;
        logic [31:0] prior;
        int          stale;
        int          n;
        int          last_acc;
        int          qt[$];
        logic [31:0] qd[$];
        logic [31:0] a;

        repeat (3) @(posedge CLK);
        #1;
        reset = 1'b0;
        chk("rst_rdy", 32'(req_ready), 32'd1);
        chk("rst_valid", 32'(resp_valid), 32'd0);
        chk("rst_rdata", resp_rdata, 32'd0);
        chk("rst_err", 32'(resp_err), 32'd0);

        // Initialise the working set with full-word writes.
        for (int i = 0; i < NWORD; i++) do_req(1'b1, 32'(i) << 2, $urandom, 4'hF, 0, rd);

        // Write then read back.
        do_req(1'b1, 32'h8, 32'hDEADBEEF, 4'hF, 0, rd);
        chk("wr_rdata_zero", rd, 32'd0);
        do_req(1'b0, 32'h8, 32'd0, 4'h0, 0, rd);
        chk("rd_deadbeef", rd, 32'hDEADBEEF);

        // Misaligned and out-of-range accesses; word 1 must not move.
        prior = mem_m[1];
        do_req(1'b0, 32'h6, 32'd0, 4'hF, 0, rd);
        do_req(1'b0, 32'h400, 32'd0, 4'hF, 0, rd);
        do_req(1'b1, 32'h6, 32'hBAD0BAD0, 4'hF, 0, rd);
        do_req(1'b1, 32'h400, 32'hBAD1BAD1, 4'hF, 0, rd);
        do_req(1'b0, 32'h4, 32'd0, 4'hF, 0, rd);
        chk("word1_kept", rd, prior);

        // Byte-enable merge.
        do_req(1'b1, 32'h0, 32'h11223344, 4'hF, 0, rd);
        do_req(1'b1, 32'h0, 32'hAABBCCDD, 4'b0101, 0, rd);
        do_req(1'b0, 32'h0, 32'd0, 4'h0, 0, rd);
`ifdef DMEM_BYTE_EN
        chk("be_merge", rd, 32'h11BB33DD);
        do_req(1'b1, 32'h0, 32'hFFFFFFFF, 4'b0000, 0, rd);
        do_req(1'b0, 32'h0, 32'd0, 4'h0, 0, rd);
        chk("be_noop", rd, 32'h11BB33DD);
`else
        chk("be_ignored", rd, 32'hAABBCCDD);
`endif

        // Response held for five cycles with junk requests presented.
        do_req(1'b0, 32'hC, 32'd0, 4'hF, 5, rd);

        // Reset one cycle into a write: the write must not commit.
        prior = mem_m[0];
        wait_idle("idle_wait");
        req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h0; req_wdata = 32'h12345678; req_be = 4'hF;
        @(posedge CLK); #1;
        req_valid = 1'b1;          // keep presenting: reset must win over it
        reset = 1'b1;
        @(posedge CLK); #1;
        reset = 1'b0; req_valid = 1'b0;
        chk("abort_rdy", 32'(req_ready), 32'd1);
        chk("abort_valid", 32'(resp_valid), 32'd0);
        stale = 0;
        for (int i = 0; i < LAT + 3; i++) begin
            @(posedge CLK); #1;
            if (resp_valid) stale++;
        end
        chk("abort_stale", 32'(stale), 32'd0);
        do_req(1'b0, 32'h0, 32'd0, 4'hF, 0, rd);
        chk("abort_prior", rd, prior);

        // Reset while a response is pending drops it.
        wait_idle("idle_wait");
        req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h10; req_be = 4'hF;
        @(posedge CLK); #1;
        req_valid = 1'b0;
        n = 0;
        while (!resp_valid && n < LAT + 4) begin @(posedge CLK); #1; n++; end
        chk("resp_pend", 32'(resp_valid), 32'd1);
        reset = 1'b1;
        @(posedge CLK); #1;
        reset = 1'b0;
        chk("drop_valid", 32'(resp_valid), 32'd0);
        chk("drop_rdata", resp_rdata, 32'd0);
        chk("drop_rdy", 32'(req_ready), 32'd1);

        // Randomised traffic.
        for (int k = 0; k < 60; k++) begin
            if ($urandom_range(0, 4) == 0) begin
                case ($urandom_range(0, 2))
                    0:       a = (32'($urandom_range(0, NWORD-1)) << 2) | 32'($urandom_range(1, 3));
                    1:       a = 32'(DEPTH) << 2;
                    default: a = $urandom | 32'h8000_0000;
                endcase
            end else begin
                a = 32'($urandom_range(0, NWORD-1)) << 2;
            end
            do_req(1'($urandom_range(0, 1)), a, $urandom, 4'($urandom_range(0, 15)),
                   $urandom_range(0, 3), rd);
        end

        // Throughput: requests and response-ready held high, reads only.
        wait_idle("idle_wait");
        resp_ready = 1'b1; req_we = 1'b0; req_be = 4'hF;
        last_acc = -1;
        for (int t = 0; t < 12 * (LAT + 2) + LAT + 3; t++) begin
            if (resp_valid) begin
                chk("tp_expected", 32'(qt.size() != 0), 32'd1);
                if (qt.size() != 0) begin
                    chk("tp_lat", 32'(t), 32'(qt.pop_front()));
                    chk("tp_data", resp_rdata, qd.pop_front());
                end
            end
            if (t < 12 * (LAT + 2)) begin
                req_valid = 1'b1;
                if (req_ready) begin
                    a = 32'($urandom_range(0, NWORD-1)) << 2;
                    req_addr = a;
                    qt.push_back(t + 1 + LAT);
                    qd.push_back(mem_m[a >> 2]);
                    if (last_acc >= 0) chk("tp_gap", 32'(t + 1 - last_acc), 32'(LAT + 2));
                    last_acc = t + 1;
                end
            end else begin
                req_valid = 1'b0;
            end
            @(posedge CLK); #1;
        end
        resp_ready = 1'b0;
        chk("tp_drain", 32'(qt.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
